seg_scan_display: RTL and testbench

SEG_SCAN_DISPLAY -- requirements
Module: seg_scan_display

---
 rtl/seg_scan_display.sv | 173 +++++++++++++++++
 tb/tb_seg_scan_display.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_display.sv
// seg_scan_display: iterative binary-to-BCD converter (double dabble) that
// drives a time-multiplexed 7-segment display with optional leading-zero
// blanking, overflow dash and output polarity selection.
module seg_scan_display #(
  parameter int IN_WIDTH      = 8,
  parameter int DIGITS        = 3,
  parameter int SCAN_DIV      = 1000,
  parameter bit ACTIVE_LOW    = 1'b0,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [IN_WIDTH-1:0] binaryInput,
  input  logic                inValid,
  output logic                inReady,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] bcdOut,
  output logic                overflow,
  output logic [6:0]          segmentOut,
  output logic [DIGITS-1:0]   digitSel
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int SCR_W = BCD_W + 4;
  localparam int CNT_W = $clog2(IN_WIDTH + 1);
  localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = $clog2(DIGITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IN_WIDTH - 1);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt;
  logic [IN_WIDTH-1:0] bin_sr, bin_nxt;
  logic [SCR_W-1:0]    scr, scr_nxt;
  logic                xfer, last_shift;
  logic [PRE_W-1:0]    pre;
  logic [IDX_W-1:0]    idx;
  logic [3:0]          cur_nib;
  logic [DIGITS-1:0]   lead_zero;
  logic [6:0]          seg_raw;
  logic [DIGITS-1:0]   sel_raw;

  // Add 3 to every nibble that is 5 or more, ahead of the left shift.
  function automatic logic [SCR_W-1:0] dabble_adjust(input logic [SCR_W-1:0] s);
    logic [SCR_W-1:0] r;
    r = s;
    for (int n = 0; n < SCR_W / 4; n++) begin
      if (r[4*n +: 4] >= 4'd5) r[4*n +: 4] = r[4*n +: 4] + 4'd3;
    end
    return r;
  endfunction

  // Segment pattern {a,b,c,d,e,f,g} for one BCD digit; non-decimal is dark.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1111110;
      4'd1:    return 7'b0110000;
      4'd2:    return 7'b1101101;
      4'd3:    return 7'b1111001;
      4'd4:    return 7'b0110011;
      4'd5:    return 7'b1011011;
      4'd6:    return 7'b1011111;
      4'd7:    return 7'b1110000;
      4'd8:    return 7'b1111111;
      4'd9:    return 7'b1111011;
      default: return 7'b0000000;
    endcase
  endfunction

  assign xfer       = inValid && inReady;
  assign last_shift = (state == SHIFT) && (cnt == CNT_LAST);
  assign bin_nxt    = {bin_sr[IN_WIDTH-2:0], 1'b0};
  assign scr_nxt    = {dabble_adjust(scr), bin_sr[IN_WIDTH-1]} >> 0;

  // Controller state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Controller next state and handshake outputs.
  always_comb begin
    state_nxt = state;
    inReady   = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        inReady = 1'b1;
        if (inValid) state_nxt = SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        if (cnt == CNT_LAST) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Shift-cycle counter, restarted on every accepted value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 cnt <= '0;
    else if (xfer)           cnt <= '0;
    else if (state == SHIFT) cnt <= cnt + 1'b1;
  end

  // Conversion datapath: binary shift register feeding the BCD scratch.
  always_ff @(posedge clk) begin
    if (xfer) begin
      bin_sr <= binaryInput;
      scr    <= '0;
    end else if (state == SHIFT) begin
      bin_sr <= bin_nxt;
      scr    <= scr_nxt;
    end
  end

  // Result latch; only the final shift updates the displayed value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcdOut   <= '0;
      overflow <= 1'b0;
    end else if (last_shift) begin
      bcdOut   <= scr_nxt[BCD_W-1:0];
      overflow <= |scr_nxt[SCR_W-1:BCD_W];
    end
  end

  // Free-running scan prescaler and digit index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre <= '0;
      idx <= '0;
    end else if (pre == PRE_LAST) begin
      pre <= '0;
      idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      pre <= pre + 1'b1;
    end
  end

  // lead_zero[i] is set when nibbles i up to the top digit are all zero.
  always_comb begin
    lead_zero = '0;
    lead_zero[DIGITS-1] = (bcdOut[BCD_W-1 -: 4] == 4'd0);
    for (int i = DIGITS - 2; i >= 0; i--) begin
      lead_zero[i] = lead_zero[i+1] && (bcdOut[4*i +: 4] == 4'd0);
    end
  end

  assign cur_nib = bcdOut[4*idx +: 4];
  assign sel_raw = {{(DIGITS-1){1'b0}}, 1'b1} << idx;

  // Pick the pattern for the scanned digit: dash, blank or decoded digit.
  always_comb begin
    if (overflow)                                              seg_raw = 7'b0000001;
    else if (BLANK_LEADING && (idx != '0) && lead_zero[idx])   seg_raw = 7'b0000000;
    else                                                       seg_raw = seg_decode(cur_nib);
  end

  assign segmentOut = seg_raw ^ {7{ACTIVE_LOW}};
  assign digitSel   = sel_raw ^ {DIGITS{ACTIVE_LOW}};

endmodule

// File: tb/tb_seg_scan_display.sv
// Testbench for seg_scan_display: conversion vectors, handshake timing,
// overflow, scan sequencing, polarity and reset abort.
module tb_seg_scan_display;

  logic        clk;
  logic        rst;

  logic [7:0]  bin0;
  logic        vld0, rdy0, busy0, done0, ovf0;
  logic [11:0] bcd0;
  logic [6:0]  seg0;
  logic [2:0]  dsel0;

  logic [7:0]  bin1;
  logic        vld1, rdy1, busy1, done1, ovf1;
  logic [7:0]  bcd1;
  logic [6:0]  seg1;
  logic [1:0]  dsel1;

  logic [7:0]  bin2;
  logic        vld2, rdy2, busy2, done2, ovf2;
  logic [11:0] bcd2;
  logic [6:0]  seg2;
  logic [2:0]  dsel2;

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt0 = 0;

  typedef struct packed {
    logic [11:0] bcd;
    logic        ovf;
  } sb_t;
  sb_t sbq[$];

  typedef struct {
    logic [7:0]  val;
    logic [11:0] bcd;
    logic [6:0]  s2;
    logic [6:0]  s1;
    logic [6:0]  s0;
  } vec_t;
  vec_t vecs[6];

  seg_scan_display u_dut0 (
    .clk(clk), .rst(rst), .binaryInput(bin0), .inValid(vld0), .inReady(rdy0),
    .busy(busy0), .done(done0), .bcdOut(bcd0), .overflow(ovf0),
    .segmentOut(seg0), .digitSel(dsel0)
  );

  seg_scan_display #(.IN_WIDTH(8), .DIGITS(2), .SCAN_DIV(4)) u_dut1 (
    .clk(clk), .rst(rst), .binaryInput(bin1), .inValid(vld1), .inReady(rdy1),
    .busy(busy1), .done(done1), .bcdOut(bcd1), .overflow(ovf1),
    .segmentOut(seg1), .digitSel(dsel1)
  );

  seg_scan_display #(.IN_WIDTH(8), .DIGITS(3), .SCAN_DIV(4), .ACTIVE_LOW(1'b1)) u_dut2 (
    .clk(clk), .rst(rst), .binaryInput(bin2), .inValid(vld2), .inReady(rdy2),
    .busy(busy2), .done(done2), .bcdOut(bcd2), .overflow(ovf2),
    .segmentOut(seg2), .digitSel(dsel2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every done pulse of dut0 pops the oldest expected result.
  always @(negedge clk) begin
    sb_t e;
    if (!rst && done0) begin
      done_cnt0++;
      if (sbq.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_unexpected_done: actual done with bcd 0x%0h required no done", bcd0);
      end else begin
        e = sbq.pop_front();
        check("sb_bcd", bcd0, e.bcd);
        check("sb_ovf", ovf0, e.ovf);
        check("sb_busy_in_done", busy0, 1);
        check("sb_ready_in_done", rdy0, 0);
      end
    end
  end

  task automatic xfer0(input logic [7:0] v, input bit push, input logic [11:0] ebcd);
    int guard;
    guard = 0;
    while (!rdy0 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("xfer0_ready", rdy0, 1);
    bin0 = v;
    vld0 = 1'b1;
    if (push) sbq.push_back('{ebcd, 1'b0});
    @(posedge clk);
    #1 vld0 = 1'b0;
  endtask

  task automatic wait_done0(output int k);
    k = 0;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (done0) begin
        k = i;
        break;
      end
    end
  endtask

  task automatic seg0_check(input logic [6:0] e2, input logic [6:0] e1, input logic [6:0] e0);
    logic [6:0] ex[3];
    logic [2:0] seen;
    logic [2:0] oh;
    ex[0] = e0; ex[1] = e1; ex[2] = e2;
    seen = '0;
    for (int c = 0; c < 3200 && seen != 3'b111; c++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        oh = 3'(1 << d);
        if (dsel0 == oh && !seen[d]) begin
          seen[d] = 1'b1;
          check($sformatf("seg0_digit%0d", d), seg0, ex[d]);
        end
      end
    end
    check("seg0_all_digits_seen", seen, 3'b111);
  endtask

  initial begin
    int k, d1, d2, ix, dc;
    logic [2:0] raw_sel, exp_sel;
    logic [6:0] exp_seg;
    logic [1:0] seen1;

    vecs[0] = '{8'd56,  12'h056, 7'b0000000, 7'b1011011, 7'b1011111};
    vecs[1] = '{8'd255, 12'h255, 7'b1101101, 7'b1011011, 7'b1011011};
    vecs[2] = '{8'd0,   12'h000, 7'b0000000, 7'b0000000, 7'b1111110};
    vecs[3] = '{8'd100, 12'h100, 7'b0110000, 7'b1111110, 7'b1111110};
    vecs[4] = '{8'd38,  12'h038, 7'b0000000, 7'b1111001, 7'b1111111};
    vecs[5] = '{8'd9,   12'h009, 7'b0000000, 7'b0000000, 7'b1111011};

    rst = 1'b0;
    bin0 = '0; vld0 = 1'b0;
    bin1 = '0; vld1 = 1'b0;
    bin2 = '0; vld2 = 1'b0;
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);

    // Reset state, both polarities
    check("rst_ready", rdy0, 1);
    check("rst_busy", busy0, 0);
    check("rst_done", done0, 0);
    check("rst_bcd", bcd0, 0);
    check("rst_ovf", ovf0, 0);
    check("rst_dsel", dsel0, 3'b001);
    check("rst_seg", seg0, 7'b1111110);
    check("rst_dsel_al", dsel2, 3'b110);
    check("rst_seg_al", seg2, 7'b0000001);

    // Scan sequence on the SCAN_DIV=4 active-low instance, right after release
    rst = 1'b0;
    for (int j = 0; j < 16; j++) begin
      ix = (j / 4) % 3;
      raw_sel = 3'(1 << ix);
      exp_sel = ~raw_sel;
      exp_seg = (ix == 0) ? 7'b0000001 : 7'b1111111;
      check($sformatf("scan_dsel_%0d", j), dsel2, exp_sel);
      check($sformatf("scan_seg_%0d", j), seg2, exp_seg);
      @(negedge clk);
    end

    // Table-driven conversions on the default instance
    foreach (vecs[v]) begin
      xfer0(vecs[v].val, 1'b1, vecs[v].bcd);
      wait_done0(k);
      check($sformatf("lat_done_%0d", vecs[v].val), k, 8);
      @(posedge clk);
      @(negedge clk);
      check($sformatf("lat_ready_%0d", vecs[v].val), rdy0, 1);
      check($sformatf("bcd_%0d", vecs[v].val), bcd0, vecs[v].bcd);
      seg0_check(vecs[v].s2, vecs[v].s1, vecs[v].s0);
    end

    // inValid held high: 7 then 9
    @(negedge clk);
    bin0 = 8'd7; vld0 = 1'b1;
    sbq.push_back('{12'h007, 1'b0});
    @(posedge clk);
    #1 bin0 = 8'd9;
    sbq.push_back('{12'h009, 1'b0});
    d1 = 0; d2 = 0;
    for (int i = 1; i <= 30 && d2 == 0; i++) begin
      @(posedge clk);
      #1 if (i == 10) vld0 = 1'b0;
      @(negedge clk);
      if (i == 5) check("hs_bcd_held_busy", bcd0, 12'h009);
      if (i == 8) check("hs_ready_in_done", rdy0, 0);
      if (i == 9) check("hs_ready_after_done", rdy0, 1);
      if (done0) begin
        if (d1 == 0) d1 = i;
        else         d2 = i;
      end
    end
    vld0 = 1'b0;
    check("hs_first_done", d1, 8);
    check("hs_second_done", d2, 18);
    check("hs_done_spacing", d2 - d1, 10);

    // Overflow on the two-digit instance
    @(negedge clk);
    bin1 = 8'd100; vld1 = 1'b1;
    @(posedge clk);
    #1 vld1 = 1'b0;
    k = 0;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (done1) begin
        k = i;
        break;
      end
    end
    check("ovf_lat_done", k, 8);
    check("ovf_bcd", bcd1, 8'h00);
    check("ovf_flag", ovf1, 1);
    seen1 = '0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      seen1 = seen1 | dsel1;
      check($sformatf("ovf_seg_%0d", i), seg1, 7'b0000001);
    end
    check("ovf_digits_seen", seen1, 2'b11);

    // Reset abort: display 56, then abort a conversion of 200
    xfer0(8'd56, 1'b1, 12'h056);
    wait_done0(k);
    check("pre_abort_done", k, 8);
    @(posedge clk);
    @(negedge clk);
    xfer0(8'd200, 1'b0, 12'h000);
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    check("abort_bcd_held", bcd0, 12'h056);
    check("abort_busy", busy0, 1);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("abort_bcd_cleared", bcd0, 12'h000);
    check("abort_ready", rdy0, 1);
    check("abort_busy_low", busy0, 0);
    check("abort_done_low", done0, 0);
    dc = done_cnt0;
    @(negedge clk);
    rst = 1'b0;
    repeat (15) @(negedge clk);
    check("abort_no_done", done_cnt0, dc);
    check("abort_bcd_stays", bcd0, 12'h000);

    // First transfer immediately after reset release
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bin0 = 8'd42; vld0 = 1'b1;
    sbq.push_back('{12'h042, 1'b0});
    @(posedge clk);
    #1 vld0 = 1'b0;
    wait_done0(k);
    check("post_rst_done", k, 8);
    check("post_rst_bcd", bcd0, 12'h042);
    repeat (3) @(negedge clk);
    check("sb_queue_empty", sbq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
